// File: rtl/adder_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_share_arb_pkg
// Shared constants, types and the round-robin pick helper for the shared-adder
// arbiter. No ports; imported by the interface, the adder and the top.
// -----------------------------------------------------------------------------
package adder_share_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_W     = 16;
    // The arbiter supports at most eight requesters, so a 3-bit index covers
    // every legal configuration of the pick helper.
    localparam int MAX_NREQ  = 8;
    localparam int PICK_IDXW = 3;

    typedef struct packed {
        logic                 found;
        logic [PICK_IDXW-1:0] idx;
    } rr_pick_t;

    // Scan requesters starting at ptr and wrapping modulo nreq; the first
    // valid one wins. found is low when no requester is valid.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_NREQ-1:0]  valid,
        input logic [PICK_IDXW-1:0] ptr,
        input int                   nreq
    );
        rr_pick_t             res;
        logic [PICK_IDXW-1:0] cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            cand = PICK_IDXW'((int'(ptr) + k) % nreq);
            if ((k < nreq) && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// -----------------------------------------------------------------------------
// adder_share_arb_if
// Request/response bundle of the shared-adder arbiter.
//   req_valid/req_a/req_b/req_ready : per-requester request handshake
//   rsp_valid/rsp_ready/rsp_sum/rsp_carry/rsp_id : single result channel
//   busy_cnt : saturating count of stalled request cycles
// master = requesters and result consumer, slave = the arbiter.
// -----------------------------------------------------------------------------
interface adder_share_arb_if
    import adder_share_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        busy_cnt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy_cnt
    );
endinterface

// File: rtl/adder_share_arb_add.sv
// -----------------------------------------------------------------------------
// adder_share_arb_add
// The single shared unsigned adder.
//   a_i, b_i : operands (W bits)
//   sum_o    : (a+b) mod 2^W
//   carry_o  : carry-out, derived as sum < a
// -----------------------------------------------------------------------------
module adder_share_arb_add
    import adder_share_arb_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);
    assign sum_o   = a_i + b_i;
    // An unsigned sum that wrapped is always smaller than either operand.
    assign carry_o = (sum_o < a_i);
endmodule

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
// Round-robin sharing of one adder between NREQ requesters, one add per cycle,
// result registered with the winner's ID and carry-out.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
// -----------------------------------------------------------------------------
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);

    rr_pick_t        pick_s;
    logic [IDW-1:0]  win_s;
    logic            issue_s;
    logic [NREQ-1:0] grant_s;
    logic [W-1:0]    mux_a_s;
    logic [W-1:0]    mux_b_s;
    logic [W-1:0]    add_sum_s;
    logic            add_carry_s;

    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_sum_q,   rsp_sum_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [7:0]      busy_cnt_q,  busy_cnt_d;

    // Winner selection and issue decision; the slot may be refilled while it drains.
    always_comb begin
        pick_s  = rr_pick(MAX_NREQ'(bus.req_valid), PICK_IDXW'(rr_ptr_q), NREQ);
        win_s   = IDW'(pick_s.idx);
        issue_s = pick_s.found & (~rsp_valid_q | bus.rsp_ready);
    end

    // One-hot grant, forced low while reset is asserted.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_s[i] = issue_s & rst_n & (win_s == IDW'(i));
        end
    end

    // Operand muxes in front of the shared adder.
    always_comb begin
        mux_a_s = '0;
        mux_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == IDW'(i)) begin
                mux_a_s = bus.req_a[i*W +: W];
                mux_b_s = bus.req_b[i*W +: W];
            end else begin
                mux_a_s = mux_a_s;
                mux_b_s = mux_b_s;
            end
        end
    end

    adder_share_arb_add #(.W(W)) u_add (
        .a_i     (mux_a_s),
        .b_i     (mux_b_s),
        .sum_o   (add_sum_s),
        .carry_o (add_carry_s)
    );

    // Next state of the result slot, round-robin pointer and stall counter.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        busy_cnt_d  = busy_cnt_q;
        if (issue_s) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum_s;
            rsp_carry_d = add_carry_s;
            rsp_id_d    = win_s;
            rr_ptr_d    = (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);
        end else if (bus.rsp_ready) begin
            // Drain without refill: data fields keep their last value.
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
        if (pick_s.found && !issue_s && (busy_cnt_q != 8'hFF)) begin
            busy_cnt_d = busy_cnt_q + 8'd1;
        end else begin
            busy_cnt_d = busy_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            busy_cnt_q  <= 8'd0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arb
// Directed bench for adder_share_arb with NREQ=4, W=16: a vector table of
// single-issue operations followed by round-robin, backpressure, async reset
// and counter-saturation sequences.
// -----------------------------------------------------------------------------
module tb_adder_share_arb;
    import adder_share_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    adder_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  grant;
        logic [15:0] sum;
        logic        carry;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_sum;

        // Each vector is issued from a known pointer; pointer history noted per line.
        vecs[0] = '{4'b0001, {16'h0, 16'h0, 16'h0, 16'h1234}, {16'h0, 16'h0, 16'h0, 16'h0FFF},
                    4'b0001, 16'h2233, 1'b0, 2'd0};                     // ptr 0 -> 1
        vecs[1] = '{4'b0100, {16'h0, 16'hFFFF, 16'h0, 16'h0}, {16'h0, 16'h0002, 16'h0, 16'h0},
                    4'b0100, 16'h0001, 1'b1, 2'd2};                     // ptr -> 3
        vecs[2] = '{4'b0010, {16'h0, 16'h0, 16'h8000, 16'h0}, {16'h0, 16'h0, 16'h8000, 16'h0},
                    4'b0010, 16'h0000, 1'b1, 2'd1};                     // ptr -> 2
        vecs[3] = '{4'b1000, {16'h0000, 16'h0, 16'h0, 16'h0}, {16'h0000, 16'h0, 16'h0, 16'h0},
                    4'b1000, 16'h0000, 1'b0, 2'd3};                     // ptr -> 0
        vecs[4] = '{4'b1000, {16'h7FFF, 16'h0, 16'h0, 16'h0}, {16'h0001, 16'h0, 16'h0, 16'h0},
                    4'b1000, 16'h8000, 1'b0, 2'd3};                     // ptr -> 0
        vecs[5] = '{4'b1010, {16'h1111, 16'h0, 16'h0001, 16'h0}, {16'h2222, 16'h0, 16'hFFFF, 16'h0},
                    4'b0010, 16'h0000, 1'b1, 2'd1};                     // ptr 0: 1 wins -> 2
        vecs[6] = '{4'b1010, {16'hABCD, 16'h0, 16'h5555, 16'h0}, {16'h1111, 16'h0, 16'h0001, 16'h0},
                    4'b1000, 16'hBCDE, 1'b0, 2'd3};                     // ptr 2: 3 wins -> 0

        // Reset held three cycles with a request pending: no grant may leak out.
        bus.req_valid = 4'b1111;
        bus.req_a     = 64'h0;
        bus.req_b     = 64'h0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        #1;
        chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
        repeat (3) tick();
        rst_n         = 1'b1;
        bus.req_valid = 4'b0000;
        #1;
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("idle_rsp_sum",   32'(bus.rsp_sum),   32'h0);
        chk("idle_rsp_carry", 32'(bus.rsp_carry), 32'h0);
        chk("idle_rsp_id",    32'(bus.rsp_id),    32'h0);
        chk("idle_ready",     32'(bus.req_ready), 32'h0);
        tick();
        chk("idle_busy",      32'(bus.busy_cnt),  32'h0);
        chk("idle_valid2",    32'(bus.rsp_valid), 32'h0);

        // Table of single-cycle operations, back to back.
        for (int i = 0; i < 7; i++) begin
            bus.req_valid = vecs[i].valid;
            bus.req_a     = vecs[i].a;
            bus.req_b     = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(bus.req_ready), 32'(vecs[i].grant));
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'h1);
            chk($sformatf("vec%0d_sum", i),   32'(bus.rsp_sum),   32'(vecs[i].sum));
            chk($sformatf("vec%0d_carry", i), 32'(bus.rsp_carry), 32'(vecs[i].carry));
            chk($sformatf("vec%0d_id", i),    32'(bus.rsp_id),    32'(vecs[i].id));
        end
        chk("vec_busy", 32'(bus.busy_cnt), 32'h0);

        // Round robin: all four requesters held, pointer starts at 0.
        bus.req_valid = 4'b1111;
        bus.req_a     = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        bus.req_b     = {16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr%0d_grant", i), 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            exp_sum = 16'h1000 * 16'((i % 4) + 1) + 16'h00FF;
            chk($sformatf("rr%0d_valid", i), 32'(bus.rsp_valid), 32'h1);
            chk($sformatf("rr%0d_id", i),    32'(bus.rsp_id),    32'(i % 4));
            chk($sformatf("rr%0d_sum", i),   32'(bus.rsp_sum),   32'(exp_sum));
        end

        // Backpressure: result id1 / 0x20FF held, pointer now 2, requests 0 and 2.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0101;
        bus.req_a     = {16'h0, 16'hF000, 16'h0, 16'h0100};
        bus.req_b     = {16'h0, 16'h1000, 16'h0, 16'h0001};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_grant", i), 32'(bus.req_ready), 32'h0);
            tick();
            chk($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 32'h1);
            chk($sformatf("bp%0d_sum", i),   32'(bus.rsp_sum),   32'h20FF);
            chk($sformatf("bp%0d_id", i),    32'(bus.rsp_id),    32'h1);
        end
        chk("bp_busy5", 32'(bus.busy_cnt), 32'd5);
        bus.rsp_ready = 1'b1;
        #1;
        chk("drain_grant", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("drain_valid", 32'(bus.rsp_valid), 32'h1);
        chk("drain_sum",   32'(bus.rsp_sum),   32'h0000);
        chk("drain_carry", 32'(bus.rsp_carry), 32'h1);
        chk("drain_id",    32'(bus.rsp_id),    32'h2);
        chk("drain_busy",  32'(bus.busy_cnt),  32'd5);
        bus.req_valid = 4'b0001;
        #1;
        chk("drain2_grant", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("drain2_sum", 32'(bus.rsp_sum), 32'h0101);
        chk("drain2_id",  32'(bus.rsp_id),  32'h0);

        // Async reset between edges while a result is pending (pointer is 1).
        bus.req_valid = 4'b1111;
        bus.req_a     = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        bus.req_b     = {16'h0010, 16'h0010, 16'h0010, 16'h0010};
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_busy",  32'(bus.busy_cnt),  32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("post_rst_valid", 32'(bus.rsp_valid), 32'h1);
        chk("post_rst_id",    32'(bus.rsp_id),    32'h0);
        chk("post_rst_sum",   32'(bus.rsp_sum),   32'h0011);

        // Stall long enough to hit the counter ceiling.
        bus.rsp_ready = 1'b0;
        repeat (260) tick();
        chk("busy_sat",      32'(bus.busy_cnt),  32'd255);
        chk("busy_sat_hold", 32'(bus.rsp_id),    32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 16-bit adder datapath between NREQ independent requesters.
- Round-robin arbitration, one add issued per cycle.
- Each result is registered with the winning requester's ID and carry-out.
- Sits between CPU sub-units (PC increment, address generation, ALU assist) and a single adder instance, removing duplicate adders.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand and sum width; must match the shared adder width.
- IDW, $clog2(NREQ), width of the requester ID field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  packed operand B, same packing as req_a.
- req_ready  output  NREQ  one-hot grant; the request is consumed this cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_sum  output  W  (a+b) mod 2^W.
- rsp_carry  output  1  carry-out of the addition.
- rsp_id  output  IDW  index of the requester that issued the result.
- busy_cnt  output  8  saturating count of cycles with any req_valid high and no grant.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, rr_ptr=0, busy_cnt=0. req_ready is combinational and is 0 while rst_n=0.
- Handshakes:
  - A request transfers when req_valid[i] & req_ready[i].
  - A response transfers when rsp_valid & rsp_ready.
  - A requester holds req_valid and its operands stable until granted.
- Issue condition: issue = any(req_valid) & (~rsp_valid | rsp_ready). The output slot is free, or it is being drained this same cycle; full throughput is 1 op/cycle.
- Arbitration:
  - Scan requesters starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid requester wins; at most one bit of req_ready is set.
  - On issue, rr_ptr <= (winner+1) mod NREQ. With no issue, rr_ptr holds.
- Datapath:
  - Winner's operands are muxed into the shared adder.
  - rsp_carry = (sum < a), computed with an unsigned compare.
  - Arithmetic is unsigned; sums wrap modulo 2^W.
- Latency: 1 cycle from grant to rsp_valid.
- Register update rules:
  - Issue: rsp_* <= new result, rsp_valid <= 1.
  - No issue but rsp_ready with rsp_valid: rsp_valid <= 0; data fields hold their last value.
  - Otherwise: hold.
- Backpressure: rsp_valid=1 & rsp_ready=0 forces req_ready=0. The result stays stable until accepted.
- Simultaneous drain and issue in one cycle: the new result replaces the old one, no bubble.
- Starvation bound: a continuously asserted request is granted within NREQ issue cycles.
- busy_cnt: increments when any(req_valid) & ~issue; saturates at 255; never wraps.
- Reset mid-operation:
  - The pending result is discarded and rsp_valid drops immediately.
  - Requesters must re-present requests after reset.
- NREQ=1 degenerates to a registered adder with a pass-through ready; rsp_id is held at 0.

Decomposition:
- Shared package: constants DEF_NREQ=4 and DEF_W=16, plus a function rr_pick(valid, ptr) returning the winner index and a found flag.
- One sub-module: the existing 16-bit adder, instantiated once, with operand muxes in front of it.
- Arbiter logic and the output register stay in adder_share_arb.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then no requests -> all outputs 0; req_ready=0000; busy_cnt=0.
- Single request: req 0 with a=0x1234, b=0x0FFF, rsp_ready=1 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, sum=0x2233, carry=0, id=0.
- Wrap and carry: req 2 with a=0xFFFF, b=0x0002 -> sum=0x0001, carry=1, id=2.
- Round-robin: all 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; a result every cycle.
- Backpressure: rsp_ready=0 for 5 cycles with 2 requests pending -> rsp_* stable; req_ready=0; busy_cnt increments by 5; on rsp_ready=1, the next result appears in the same cycle as the drain, with no bubble.
- Async reset mid-stream: assert rst_n low between clk edges while rsp_valid=1 -> rsp_valid=0 immediately; after release, the first grant goes to requester 0 (rr_ptr=0).
